fetch_sequencer: RTL and testbench
==================================

// Module: fetch_sequencer
// PURPOSE
//  Control FSM that sequences LC-3b instruction fetch into the instruction register.
//  Each fetch drives PC->MAR, holds a memory/cache read handshake, then MDR->IR.
//  Presents the decoded instruction to the execute control with a valid/done handshake.
//  Applies PC redirects (branch/JSR/TRAP targets) and counts retired instructions.
//  Sits between the datapath (PC, MAR, MDR, IR registers) and the cache memory port.
// PARAMETERS
//  MEM_TIMEOUT  256  cycles of mem_read with no mem_resp before mem_err is set; range 2..65535
//  CNT_W        32   width of the retired-instruction counter
// PORTS
//  clk           in   1      clock; all state changes on its rising edge
//  reset         in   1      synchronous, active-high reset
//  run           in   1      permits starting a new fetch (level)
//  load_pc       out  1      PC register load enable
//  pcmux_sel     out  1      0 = PC+2, 1 = redirect target (from execute)
//  load_mar      out  1      MAR load enable (MAR <- PC)
//  load_mdr      out  1      MDR load enable (MDR <- mem_rdata)
//  mem_read      out  1      memory read request, held until mem_resp
//  mem_resp      in   1      memory read complete, 1-cycle pulse
//  load_ir       out  1      IR load enable (IR <- MDR)
//  dec_valid     out  1      IR holds a valid instruction for execute
//  exec_done     in   1      execute finished the current instruction (1-cycle pulse)
//  redirect      in   1      qualifies exec_done: next PC is the redirect target
//  mem_err       out  1      sticky: read timed out; cleared only by reset
//  retired       out  CNT_W  count of exec_done pulses accepted
// BEHAVIOUR
//  Reset: state IDLE; all load enables, mem_read, dec_valid, mem_err = 0; retired = 0.
//  All control outputs are Moore (state decode) except load_mdr (= S_READ & mem_resp)
//   and load_pc/pcmux_sel in S_DECODE (Mealy on exec_done & redirect).
//  States and transitions:
//   IDLE:   all outputs 0. Go to ADDR if run=1 and mem_err=0.
//   ADDR:   load_mar=1, load_pc=1, pcmux_sel=0 (MAR<-PC, PC<-PC+2). Go to READ.
//   READ:   mem_read=1. When mem_resp=1: load_mdr=1, go to LOADIR.
//           mem_resp in the first READ cycle is accepted (zero-wait memory).
//           Wait counter increments each READ cycle without mem_resp. When it reaches
//           MEM_TIMEOUT: set mem_err, drop mem_read, go to IDLE.
//   LOADIR: load_ir=1. Go to DECODE.
//   DECODE: dec_valid=1. IR fields are valid this cycle. Wait for exec_done.
//           exec_done & redirect: load_pc=1, pcmux_sel=1.
//           exec_done (either case): retired += 1. Go to ADDR if run=1, else IDLE.
//  Latency: zero-wait memory gives 3 cycles from leaving IDLE to dec_valid.
//   Back-to-back steady-state throughput is 1 instr per (4 + mem wait + exec) cycles.
//  Boundary conditions:
//   mem_resp outside READ, and exec_done/redirect outside DECODE: ignored, no state change.
//   redirect without exec_done: ignored.
//   Redirect PC load in DECODE is never overridden. The PC+2 load occurs later, in ADDR.
//   retired wraps modulo 2^CNT_W with no saturation.
//   Wait counter clears on entry to READ. It never counts outside READ.
//   run deasserted mid-fetch: the fetch completes to DECODE; the stop takes effect after exec_done.
//   reset in any state (incl. mid-READ): next edge forces IDLE and reset values.
//    mem_read is low in the cycle after the reset edge.
//   mem_err=1 blocks IDLE->ADDR until reset.
// STRUCTURE
//  Shared package lc3b_types gains:
//   - fetch_state_t enum {IDLE, ADDR, READ, LOADIR, DECODE};
//   - pcmux constants PCMUX_PLUS2=1'b0, PCMUX_TARGET=1'b1.
//  One sub-module, mem_wait_timer: clear, enable, LIMIT parameter; outputs expired.
//  FSM next-state and output decode live in this module.
// TESTING
//  1 Zero-wait fetch: reset 2 cycles, run=1, mem_resp in first READ cycle ->
//    load_mar@1, mem_read+load_mdr@2, load_ir@3, dec_valid@4; PC+2 load once.
//  2 Wait states: mem_resp after 5 READ cycles -> mem_read high exactly 6 cycles,
//    single load_mdr, no mem_err.
//  3 Redirect: exec_done=1, redirect=1 in DECODE -> load_pc=1, pcmux_sel=1 that cycle.
//    Next ADDR has pcmux_sel=0. retired 0->1.
//  4 Timeout: MEM_TIMEOUT=4, mem_resp never -> mem_err=1 after 4 READ cycles;
//    FSM sits in IDLE with run=1; a stray mem_resp is ignored.
//  5 Reset mid-READ: assert reset in the 2nd READ cycle -> next cycle all outputs 0,
//    retired=0; a later fetch behaves as in scenario 1.
//  6 Counter wrap: CNT_W=4, 16 exec_done pulses -> retired returns to 0.
//    Spurious exec_done in READ leaves the count unchanged.

Source files
------------

// File: rtl/fetch_sequencer_pkg.sv
// Shared LC-3b control types: fetch FSM states and PC mux select encodings.
// Imported by the fetch sequencer, its interface users and the bench.
package lc3b_types;

   typedef enum logic [2:0] {
      IDLE,
      ADDR,
      READ,
      LOADIR,
      DECODE
   } fetch_state_t;

   localparam logic PCMUX_PLUS2  = 1'b0;
   localparam logic PCMUX_TARGET = 1'b1;

endpackage

// File: rtl/fetch_sequencer_if.sv
// Handshake bundle between the fetch sequencer (master) and the datapath,
// cache read port and execute control (slave).
interface fetch_sequencer_if;

   logic load_pc;
   logic pcmux_sel;
   logic load_mar;
   logic load_mdr;
   logic mem_read;
   logic mem_resp;
   logic load_ir;
   logic dec_valid;
   logic exec_done;
   logic redirect;

   modport master (
      output load_pc, pcmux_sel, load_mar, load_mdr, mem_read, load_ir, dec_valid,
      input  mem_resp, exec_done, redirect
   );

   modport slave (
      input  load_pc, pcmux_sel, load_mar, load_mdr, mem_read, load_ir, dec_valid,
      output mem_resp, exec_done, redirect
   );

endinterface

// File: rtl/fetch_sequencer_mem_wait_timer.sv
// Counts READ cycles spent waiting on the memory; flags expiry on the
// LIMIT-th consecutive waiting cycle so the FSM can abandon the read.
module mem_wait_timer #(
   parameter int LIMIT = 256
) (
   input  logic clk,
   input  logic reset,
   input  logic i_clear,
   input  logic i_enable,
   output logic o_expired
);

   localparam int W = $clog2(LIMIT + 1);

   logic [W-1:0] r_count;

   // Expiry is combinational so the FSM reacts in the same cycle the limit is reached.
   assign o_expired = i_enable && (r_count == W'(LIMIT - 1));

   always_ff @(posedge clk) begin
      if (reset || i_clear) begin
         r_count <= '0;
      end else if (i_enable && !o_expired) begin
         r_count <= r_count + W'(1);
      end
   end

endmodule

// File: rtl/fetch_sequencer.sv
// LC-3b instruction fetch control: PC->MAR, memory read handshake, MDR->IR,
// then hands the instruction to execute and applies redirects on completion.
module fetch_sequencer
   import lc3b_types::*;
#(
   parameter int MEM_TIMEOUT = 256,
   parameter int CNT_W       = 32
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 i_run,
   fetch_sequencer_if.master    bus,
   output logic                 o_mem_err,
   output logic [CNT_W-1:0]     o_retired
);

   fetch_state_t r_state;
   logic         r_loadPc;
   logic         r_loadMar;
   logic         r_memRead;
   logic         r_loadIr;
   logic         r_decValid;
   logic         w_redirectLoad;
   logic         w_timerClear;
   logic         w_timerEnable;
   logic         w_timerExpired;

   assign w_redirectLoad = (r_state == DECODE) && bus.exec_done && bus.redirect;
   assign w_timerClear   = (r_state == ADDR);
   assign w_timerEnable  = (r_state == READ) && !bus.mem_resp;

   assign bus.load_pc   = r_loadPc | w_redirectLoad;
   assign bus.pcmux_sel = w_redirectLoad ? PCMUX_TARGET : PCMUX_PLUS2;
   assign bus.load_mar  = r_loadMar;
   assign bus.load_mdr  = (r_state == READ) && bus.mem_resp;
   assign bus.mem_read  = r_memRead;
   assign bus.load_ir   = r_loadIr;
   assign bus.dec_valid = r_decValid;

   mem_wait_timer #(
      .LIMIT (MEM_TIMEOUT)
   ) u_memWaitTimer (
      .clk       (clk),
      .reset     (reset),
      .i_clear   (w_timerClear),
      .i_enable  (w_timerEnable),
      .o_expired (w_timerExpired)
   );

   // Moore outputs are registered alongside the state, so each is set on the edge entering its state.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= IDLE;
         r_loadPc   <= 1'b0;
         r_loadMar  <= 1'b0;
         r_memRead  <= 1'b0;
         r_loadIr   <= 1'b0;
         r_decValid <= 1'b0;
         o_mem_err  <= 1'b0;
         o_retired  <= '0;
      end else begin
         r_loadPc   <= 1'b0;
         r_loadMar  <= 1'b0;
         r_memRead  <= 1'b0;
         r_loadIr   <= 1'b0;
         r_decValid <= 1'b0;
         case (r_state)
            IDLE: begin
               if (i_run && !o_mem_err) begin
                  r_state   <= ADDR;
                  r_loadPc  <= 1'b1;
                  r_loadMar <= 1'b1;
               end
            end
            ADDR: begin
               r_state   <= READ;
               r_memRead <= 1'b1;
            end
            READ: begin
               if (bus.mem_resp) begin
                  r_state  <= LOADIR;
                  r_loadIr <= 1'b1;
               end else if (w_timerExpired) begin
                  r_state   <= IDLE;
                  o_mem_err <= 1'b1;
               end else begin
                  r_memRead <= 1'b1;
               end
            end
            LOADIR: begin
               r_state    <= DECODE;
               r_decValid <= 1'b1;
            end
            DECODE: begin
               if (bus.exec_done) begin
                  o_retired <= o_retired + CNT_W'(1);
                  if (i_run) begin
                     r_state   <= ADDR;
                     r_loadPc  <= 1'b1;
                     r_loadMar <= 1'b1;
                  end else begin
                     r_state <= IDLE;
                  end
               end else begin
                  r_decValid <= 1'b1;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench: default-parameter instance for fetch/wait/redirect/reset,
// small instance (timeout 4, 4-bit counter) for timeout and wrap.
module tb_fetch_sequencer;

   logic       clk;
   logic       reset;
   logic       runA;
   logic       runB;
   logic       errA;
   logic       errB;
   logic [31:0] retiredA;
   logic [3:0]  retiredB;
   int         checks;
   int         errors;

   fetch_sequencer_if ifA ();
   fetch_sequencer_if ifB ();

   fetch_sequencer dutA (
      .clk       (clk),
      .reset     (reset),
      .i_run     (runA),
      .bus       (ifA),
      .o_mem_err (errA),
      .o_retired (retiredA)
   );

   fetch_sequencer #(
      .MEM_TIMEOUT (4),
      .CNT_W       (4)
   ) dutB (
      .clk       (clk),
      .reset     (reset),
      .i_run     (runB),
      .bus       (ifB),
      .o_mem_err (errB),
      .o_retired (retiredB)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Output vector order: load_pc, pcmux_sel, load_mar, load_mdr, mem_read, load_ir, dec_valid, mem_err.
   function automatic logic [7:0] outsA();
      return {ifA.load_pc, ifA.pcmux_sel, ifA.load_mar, ifA.load_mdr,
              ifA.mem_read, ifA.load_ir, ifA.dec_valid, errA};
   endfunction

   function automatic logic [7:0] outsB();
      return {ifB.load_pc, ifB.pcmux_sel, ifB.load_mar, ifB.load_mdr,
              ifB.mem_read, ifB.load_ir, ifB.dec_valid, errB};
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance to the next falling edge; inputs change here and outputs settle 1 time unit later.
   task automatic applyStimulus();
      @(negedge clk);
   endtask

   initial begin
      checks = 0;
      errors = 0;
      reset = 1'b1;
      runA = 1'b0;
      runB = 1'b0;
      ifA.mem_resp = 1'b0; ifA.exec_done = 1'b0; ifA.redirect = 1'b0;
      ifB.mem_resp = 1'b0; ifB.exec_done = 1'b0; ifB.redirect = 1'b0;

      applyStimulus();
      applyStimulus();
      #1;
      checkOutput("reset_outsA", 32'(outsA()), 32'h00);
      checkOutput("reset_retiredA", retiredA, 32'd0);
      checkOutput("reset_outsB", 32'(outsB()), 32'h00);

      // Zero-wait fetch
      reset = 1'b0; runA = 1'b1; #1;
      checkOutput("s1_idle", 32'(outsA()), 32'h00);
      applyStimulus(); #1;
      checkOutput("s1_addr", 32'(outsA()), 32'hA0);
      applyStimulus(); ifA.mem_resp = 1'b1; #1;
      checkOutput("s1_read", 32'(outsA()), 32'h18);
      applyStimulus(); ifA.mem_resp = 1'b0; #1;
      checkOutput("s1_loadir", 32'(outsA()), 32'h04);
      applyStimulus(); #1;
      checkOutput("s1_decode", 32'(outsA()), 32'h02);
      applyStimulus(); ifA.exec_done = 1'b1; #1;
      checkOutput("s1_exec_plain", 32'(outsA()), 32'h02);
      applyStimulus(); ifA.exec_done = 1'b0; #1;
      checkOutput("s1_next_addr", 32'(outsA()), 32'hA0);
      checkOutput("s1_retired", retiredA, 32'd1);

      // Five wait states then response: mem_read high six cycles
      for (int i = 0; i < 5; i++) begin
         applyStimulus(); #1;
         checkOutput($sformatf("s2_wait%0d", i), 32'(outsA()), 32'h08);
      end
      applyStimulus(); ifA.mem_resp = 1'b1; #1;
      checkOutput("s2_resp", 32'(outsA()), 32'h18);
      applyStimulus(); ifA.mem_resp = 1'b0; #1;
      checkOutput("s2_loadir", 32'(outsA()), 32'h04);
      applyStimulus(); #1;
      checkOutput("s2_decode", 32'(outsA()), 32'h02);

      // Redirect alone is ignored; with exec_done it loads the target
      applyStimulus(); ifA.redirect = 1'b1; #1;
      checkOutput("s3_redir_only", 32'(outsA()), 32'h02);
      applyStimulus(); ifA.exec_done = 1'b1; #1;
      checkOutput("s3_redirect", 32'(outsA()), 32'hC2);
      checkOutput("s3_retired_before", retiredA, 32'd1);
      applyStimulus(); ifA.exec_done = 1'b0; ifA.redirect = 1'b0; runA = 1'b0; #1;
      checkOutput("s3_addr_plus2", 32'(outsA()), 32'hA0);
      checkOutput("s3_retired_after", retiredA, 32'd2);

      // run dropped mid-fetch: fetch completes, stop after exec_done
      applyStimulus(); ifA.mem_resp = 1'b1; #1;
      checkOutput("stop_read", 32'(outsA()), 32'h18);
      applyStimulus(); ifA.mem_resp = 1'b0; #1;
      checkOutput("stop_loadir", 32'(outsA()), 32'h04);
      applyStimulus(); #1;
      checkOutput("stop_decode", 32'(outsA()), 32'h02);
      applyStimulus(); ifA.exec_done = 1'b1; #1;
      applyStimulus(); ifA.exec_done = 1'b0; #1;
      checkOutput("stop_idle", 32'(outsA()), 32'h00);
      checkOutput("stop_retired", retiredA, 32'd3);
      applyStimulus(); ifA.mem_resp = 1'b1; ifA.exec_done = 1'b1; #1;
      checkOutput("stray_idle", 32'(outsA()), 32'h00);
      applyStimulus(); ifA.mem_resp = 1'b0; ifA.exec_done = 1'b0; runA = 1'b1; #1;
      checkOutput("stray_retired", retiredA, 32'd3);
      checkOutput("stray_still_idle", 32'(outsA()), 32'h00);

      // Reset in the second READ cycle
      applyStimulus(); #1;
      checkOutput("s5_addr", 32'(outsA()), 32'hA0);
      applyStimulus(); #1;
      checkOutput("s5_read1", 32'(outsA()), 32'h08);
      applyStimulus(); reset = 1'b1; #1;
      checkOutput("s5_read2", 32'(outsA()), 32'h08);
      applyStimulus(); reset = 1'b0; #1;
      checkOutput("s5_after_reset", 32'(outsA()), 32'h00);
      checkOutput("s5_retired", retiredA, 32'd0);
      applyStimulus(); #1;
      checkOutput("s5_re_addr", 32'(outsA()), 32'hA0);
      applyStimulus(); ifA.mem_resp = 1'b1; #1;
      checkOutput("s5_re_read", 32'(outsA()), 32'h18);
      applyStimulus(); ifA.mem_resp = 1'b0; #1;
      checkOutput("s5_re_loadir", 32'(outsA()), 32'h04);
      applyStimulus(); runA = 1'b0; #1;
      checkOutput("s5_re_decode", 32'(outsA()), 32'h02);
      applyStimulus(); ifA.exec_done = 1'b1; #1;
      applyStimulus(); ifA.exec_done = 1'b0; #1;
      checkOutput("s5_re_idle", 32'(outsA()), 32'h00);
      checkOutput("s5_re_retired", retiredA, 32'd1);

      // Timeout with MEM_TIMEOUT=4
      runB = 1'b1; #1;
      checkOutput("s4_idle", 32'(outsB()), 32'h00);
      applyStimulus(); #1;
      checkOutput("s4_addr", 32'(outsB()), 32'hA0);
      for (int i = 0; i < 4; i++) begin
         applyStimulus(); #1;
         checkOutput($sformatf("s4_wait%0d", i), 32'(outsB()), 32'h08);
      end
      applyStimulus(); #1;
      checkOutput("s4_err_idle", 32'(outsB()), 32'h01);
      applyStimulus(); ifB.mem_resp = 1'b1; #1;
      checkOutput("s4_stray_resp", 32'(outsB()), 32'h01);
      applyStimulus(); ifB.mem_resp = 1'b0; #1;
      checkOutput("s4_blocked", 32'(outsB()), 32'h01);

      applyStimulus(); reset = 1'b1; runB = 1'b0;
      applyStimulus(); reset = 1'b0; #1;
      checkOutput("s6_reset_outs", 32'(outsB()), 32'h00);
      checkOutput("s6_reset_retired", 32'(retiredB), 32'd0);

      // Sixteen instructions on a 4-bit counter; spurious exec_done in READ on the first
      runB = 1'b1;
      for (int i = 0; i < 16; i++) begin
         applyStimulus(); ifB.exec_done = 1'b0; #1;
         checkOutput($sformatf("s6_addr%0d", i), 32'(outsB()), 32'hA0);
         checkOutput($sformatf("s6_count%0d", i), 32'(retiredB), 32'(i));
         if (i == 0) begin
            applyStimulus(); ifB.exec_done = 1'b1; #1;
            checkOutput("s6_spurious", 32'(outsB()), 32'h08);
            applyStimulus(); ifB.exec_done = 1'b0; #1;
            checkOutput("s6_spurious_count", 32'(retiredB), 32'd0);
            ifB.mem_resp = 1'b1; #1;
         end else begin
            applyStimulus(); ifB.mem_resp = 1'b1; #1;
         end
         checkOutput($sformatf("s6_read%0d", i), 32'(outsB()), 32'h18);
         applyStimulus(); ifB.mem_resp = 1'b0; #1;
         applyStimulus(); ifB.exec_done = 1'b1; #1;
         checkOutput($sformatf("s6_decode%0d", i), 32'(outsB()), 32'h02);
      end
      applyStimulus(); ifB.exec_done = 1'b0; runB = 1'b0; #1;
      checkOutput("s6_wrap", 32'(retiredB), 32'd0);
      checkOutput("s6_final_addr", 32'(outsB()), 32'hA0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
